multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multi-cycle control FSM for the RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and write-back over a shared memory port with a ready handshake. It generates every datapath strobe per state, adds JAL/JALR/HALT handling, a memory-wait timeout and optional illegal-opcode trapping. It sits between the instruction register's opcode field and the multi-cycle datapath.

## Interface
Parameters:
- TIMEOUT_W, 4: width of the memory-wait counter.
- MEM_TIMEOUT, 12: maximum number of cycles to wait for mem_ready; 0 disables the timeout. Must be < 2^TIMEOUT_W.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instruction[6:0] from the external IR; sampled only in DECODE.
- br_taken  in  1  ALU branch-compare result; valid in EXEC.
- mem_ready  in  1  memory completion; sampled only in FETCH/MEM.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_sel  out  1  address source: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = JAL target, 11 = JALR target.
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- reg_write  out  1  register file write.
- wb_sel  out  2  00 = ALU, 01 = memory data, 10 = PC+4.
- halted  out  1  in HALT state.
- mem_timeout  out  1  sticky; memory wait exceeded.
- illegal_instr  out  1  sticky; unknown opcode (tied 0 without macro).
- state  out  3  debug: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5, ERROR = 6.

## Operation
- Opcode classes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, HALT 1111111.
- The class is latched internally in DECODE. Later states ignore opcode.
- All outputs default to 0. Only the listed outputs assert in each state.
- FETCH:
  - Asserts mem_req, mem_sel = 0.
  - On mem_ready: ir_write = 1, then go to DECODE. Otherwise stay.
- DECODE:
  - HALT goes to HALT.
  - Known class goes to EXEC.
  - Unknown class: see Configuration.
- EXEC:
  - R: alu_op = 10, alu_src_b = 0, next WB.
  - I: alu_op = 10, alu_src_b = 1, next WB.
  - LW/SW: alu_op = 00, alu_src_b = 1, next MEM.
  - BR: alu_op = 01, pc_write = 1, pc_src = br_taken ? 01 : 00, next FETCH.
  - JAL/JALR: next WB, no strobes.
- MEM:
  - Asserts mem_req, mem_sel = 1, mem_we = (SW). Holds alu_op = 00, alu_src_b = 1 stable.
  - On mem_ready: LW goes to WB; SW asserts pc_write, pc_src = 00 and goes to FETCH.
- WB:
  - Asserts reg_write and pc_write.
  - wb_sel: LW 01, JAL/JALR 10, otherwise 00.
  - pc_src: JAL 10, JALR 11, otherwise 00.
  - Next FETCH.
- HALT: halted = 1; terminal until reset.
- ERROR: all strobes 0; sticky flags held; terminal until reset.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each cycle mem_ready is low.
  - When it reaches MEM_TIMEOUT with mem_ready still low, go to ERROR and set mem_timeout.
  - mem_ready high in the limit cycle wins; the access completes normally.
  - The counter saturates and never wraps.

## Timing
- Outputs are Moore decodes of state, plus the latched class and br_taken in EXEC.
- Latencies with mem_ready high on first request:
  - BR: 3 cycles.
  - R/I/JAL/JALR/SW: 4 cycles.
  - LW: 5 cycles.
  - Each additional wait cycle adds 1.
- mem_req stays high continuously until the cycle mem_ready is sampled high.
- Reset:
  - In the reset cycle all outputs are 0, the counter is 0 and sticky flags are cleared.
  - The first cycle after reset is FETCH with mem_req = 1.
  - Reset mid-access abandons the access with no pc_write or reg_write.
  - Reset overrides HALT and ERROR.
- mem_ready outside FETCH/MEM is ignored.

## Configuration
- MULTICYCLE_CTRL_ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE goes to ERROR next cycle and sets illegal_instr.
- Not defined:
  - An unknown opcode is a NOP: DECODE asserts pc_write, pc_src = 00, next FETCH.
  - illegal_instr is tied 0.

## Test plan
- Reset, then opcode 0110011, mem_ready = 1 -> state sequence 0, 1, 2, 4, 0; reg_write = 1 only in WB with wb_sel = 00, pc_write = 1, pc_src = 00.
- LW (0000011), mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_sel = 1, mem_we = 0; then WB with wb_sel = 01; total 8 cycles.
- BR (1100011), br_taken = 1 -> EXEC asserts pc_write with pc_src = 01, 3 cycles. Repeat with br_taken = 0 -> pc_src = 00.
- JALR (1100111) -> WB asserts wb_sel = 10, pc_src = 11. JAL (1101111) -> pc_src = 10.
- mem_ready held low in FETCH, MEM_TIMEOUT = 12 -> ERROR after 12 wait cycles, mem_timeout = 1, all strobes 0 for 20 cycles; reset returns to FETCH with flags cleared.
- Opcode 1111111 -> halted = 1 for 20 cycles. Opcode 0000000 with the macro -> ERROR, illegal_instr = 1. Without the macro -> DECODE pc_write = 1, pc_src = 00, back to FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a ready-handshaked memory port.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to send unknown opcodes to ERROR instead of treating them as NOPs.
module multicycle_controller #(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src_b,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic       mem_timeout,
  output logic       illegal_instr,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_HALT = 3'd5, S_ERROR = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_HALT, C_BAD
  } cls_t;

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

  state_t               st;
  cls_t                 cls, dec_cls;
  logic [TIMEOUT_W-1:0] cnt, cnt_inc;
  logic                 expire;
  logic                 tmo_q;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic                 ill_q;
`endif

  always_comb begin
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LW;
      7'b0100011: dec_cls = C_SW;
      7'b1100011: dec_cls = C_BR;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b1111111: dec_cls = C_HALT;
      default:    dec_cls = C_BAD;
    endcase
  end

  // Counter saturates; expiry fires in the MEM_TIMEOUT-th consecutive wait cycle unless ready arrives then.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + TIMEOUT_W'(1);
  assign expire  = !mem_ready && (MEM_TIMEOUT != 0) && (cnt == LIMIT - TIMEOUT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_FETCH;
      cls   <= C_BAD;
      cnt   <= '0;
      tmo_q <= 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      ill_q <= 1'b0;
`endif
    end else begin
      case (st)
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            cnt <= '0;
            if (st == S_FETCH)   st <= S_DECODE;
            else if (cls == C_LW) st <= S_WB;
            else                 st <= S_FETCH;
          end else if (expire) begin
            st    <= S_ERROR;
            tmo_q <= 1'b1;
            cnt   <= cnt_inc;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DECODE: begin
          cls <= dec_cls;
          cnt <= '0;
          case (dec_cls)
            C_HALT: st <= S_HALT;
            C_BAD: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
              st    <= S_ERROR;
              ill_q <= 1'b1;
`else
              st    <= S_FETCH;
`endif
            end
            default: st <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          cnt <= '0;
          case (cls)
            C_LW, C_SW: st <= S_MEM;
            C_BR:       st <= S_FETCH;
            default:    st <= S_WB;
          endcase
        end
        S_WB: begin
          cnt <= '0;
          st  <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state; the reset cycle forces everything low.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_sel       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    alu_op        = 2'b00;
    alu_src_b     = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    halted        = 1'b0;
    mem_timeout   = 1'b0;
    illegal_instr = 1'b0;
    state         = 3'd0;
    if (!reset) begin
      state       = st;
      mem_timeout = tmo_q;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      illegal_instr = ill_q;
`endif
      case (st)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        S_DECODE: pc_write = (dec_cls == C_BAD);
`endif
        S_EXEC: begin
          case (cls)
            C_R: alu_op = 2'b10;
            C_I: begin
              alu_op    = 2'b10;
              alu_src_b = 1'b1;
            end
            C_LW, C_SW: alu_src_b = 1'b1;
            C_BR: begin
              alu_op   = 2'b01;
              pc_write = 1'b1;
              pc_src   = br_taken ? 2'b01 : 2'b00;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_sel   = 1'b1;
          mem_we    = (cls == C_SW);
          alu_src_b = 1'b1;
          pc_write  = mem_ready && (cls == C_SW);
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          if (cls == C_LW)                        wb_sel = 2'b01;
          else if (cls == C_JAL || cls == C_JALR) wb_sel = 2'b10;
          if (cls == C_JAL)       pc_src = 2'b10;
          else if (cls == C_JALR) pc_src = 2'b11;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors, hand-derived per instruction class.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset, br_taken, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, mem_sel, ir_write, pc_write, alu_src_b, reg_write;
  logic       halted, mem_timeout, illegal_instr;
  logic [1:0] pc_src, alu_op, wb_sel;
  logic [2:0] state;
  int         checks = 0, failures = 0;

  multicycle_controller #(.TIMEOUT_W(4), .MEM_TIMEOUT(12)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .wb_sel(wb_sel), .halted(halted), .mem_timeout(mem_timeout),
    .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {state, mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, alu_op,
                alu_src_b, reg_write, wb_sel, halted, mem_timeout, illegal_instr};

  // Packs one expected output vector in the same field order as obs.
  function automatic logic [18:0] E(input int st, req, we, sel, irw, pcw, pcs, aop,
                                    srcb, rw, wbs, h, t, il);
    return {3'(st), 1'(req), 1'(we), 1'(sel), 1'(irw), 1'(pcw), 2'(pcs), 2'(aop),
            1'(srcb), 1'(rw), 2'(wbs), 1'(h), 1'(t), 1'(il)};
  endfunction

  logic [18:0] f_go, f_wait, dec;

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011; br_taken = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL reset_cycle got=%h exp=%h", obs, 19'h0); end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk); checks++;
    if (obs !== f_wait) begin failures++; $display("FAIL reset_first_fetch got=%h exp=%h", obs, f_wait); end
    @(posedge clk); #1;
  endtask

  task automatic test_r_type();
    logic [19:0] tv[$];
    opcode = 7'b0110011;
    tv.push_back({1'b1, f_go});
    tv.push_back({1'b1, dec});
    tv.push_back({1'b1, E(2,0,0,0,0,0,0,2,0,0,0,0,0,0)});
    tv.push_back({1'b1, E(4,0,0,0,0,1,0,0,0,1,0,0,0,0)});
    foreach (tv[k]) begin
      if (k == 2) opcode = 7'b1111111;
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL r_type cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_i_type();
    logic [19:0] tv[$];
    opcode = 7'b0010011;
    tv.push_back({1'b1, f_go});
    tv.push_back({1'b1, dec});
    tv.push_back({1'b1, E(2,0,0,0,0,0,0,2,1,0,0,0,0,0)});
    tv.push_back({1'b1, E(4,0,0,0,0,1,0,0,0,1,0,0,0,0)});
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL i_type cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [19:0] tv[$];
    opcode = 7'b0000011;
    tv.push_back({1'b1, f_go});
    tv.push_back({1'b1, dec});
    tv.push_back({1'b1, E(2,0,0,0,0,0,0,0,1,0,0,0,0,0)});
    for (int k = 0; k < 3; k++) tv.push_back({1'b0, E(3,1,0,1,0,0,0,0,1,0,0,0,0,0)});
    tv.push_back({1'b1, E(3,1,0,1,0,0,0,0,1,0,0,0,0,0)});
    tv.push_back({1'b0, E(4,0,0,0,0,1,0,0,0,1,1,0,0,0)});
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL load_wait cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    logic [19:0] tv[$];
    opcode = 7'b0100011;
    tv.push_back({1'b1, f_go});
    tv.push_back({1'b1, dec});
    tv.push_back({1'b1, E(2,0,0,0,0,0,0,0,1,0,0,0,0,0)});
    tv.push_back({1'b0, E(3,1,1,1,0,0,0,0,1,0,0,0,0,0)});
    tv.push_back({1'b1, E(3,1,1,1,0,1,0,0,1,0,0,0,0,0)});
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL store cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [19:0] tv[$];
    logic        tk[$];
    opcode = 7'b1100011;
    for (int r = 0; r < 2; r++) begin
      tv.push_back({1'b1, f_go});                               tk.push_back(1'(1 - r));
      tv.push_back({1'b1, dec});                                tk.push_back(1'(r));
      tv.push_back({1'b1, E(2,0,0,0,0,1,1-r,1,0,0,0,0,0,0)});   tk.push_back(1'(1 - r));
    end
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      br_taken  = tk[k];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL branch cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
    br_taken = 1'b0;
  endtask

  task automatic test_jumps();
    logic [19:0] tv[$];
    logic [6:0]  op[$];
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) op.push_back(r == 0 ? 7'b1100111 : 7'b1101111);
      tv.push_back({1'b1, f_go});
      tv.push_back({1'b1, dec});
      tv.push_back({1'b1, E(2,0,0,0,0,0,0,0,0,0,0,0,0,0)});
      tv.push_back({1'b1, E(4,0,0,0,0,1,3-r,0,0,1,2,0,0,0)});
    end
    foreach (tv[k]) begin
      opcode    = op[k];
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL jumps cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_timeout();
    logic [19:0] tv[$];
    opcode = 7'b0110011;
    for (int k = 0; k < 12; k++) tv.push_back({1'b0, f_wait});
    for (int k = 0; k < 20; k++) tv.push_back({1'(k % 2), E(6,0,0,0,0,0,0,0,0,0,0,0,1,0)});
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL fetch_timeout cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    apply_reset();
    @(negedge clk); checks++;
    if (obs !== f_wait) begin failures++; $display("FAIL timeout_reset_clears got=%h exp=%h", obs, f_wait); end
    @(posedge clk); #1;
  endtask

  task automatic test_limit_win();
    logic [19:0] tv[$];
    apply_reset();
    opcode = 7'b1100011; br_taken = 1'b0;
    for (int k = 0; k < 11; k++) tv.push_back({1'b0, f_wait});
    tv.push_back({1'b1, f_go});
    tv.push_back({1'b0, dec});
    tv.push_back({1'b0, E(2,0,0,0,0,1,0,1,0,0,0,0,0,0)});
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL limit_win cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_timeout();
    logic [19:0] tv[$];
    opcode = 7'b0000011;
    tv.push_back({1'b1, f_go});
    tv.push_back({1'b0, dec});
    tv.push_back({1'b0, E(2,0,0,0,0,0,0,0,1,0,0,0,0,0)});
    for (int k = 0; k < 12; k++) tv.push_back({1'b0, E(3,1,0,1,0,0,0,0,1,0,0,0,0,0)});
    for (int k = 0; k < 3; k++)  tv.push_back({1'b1, E(6,0,0,0,0,0,0,0,0,0,0,0,1,0)});
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL mem_timeout cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
    apply_reset();
  endtask

  task automatic test_halt();
    logic [19:0] tv[$];
    opcode = 7'b1111111;
    tv.push_back({1'b1, f_go});
    tv.push_back({1'b1, dec});
    for (int k = 0; k < 20; k++) tv.push_back({1'(k % 2), E(5,0,0,0,0,0,0,0,0,0,0,1,0,0)});
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL halt cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
    apply_reset();
  endtask

  task automatic test_illegal();
    logic [19:0] tv[$];
    opcode = 7'b0000000;
    tv.push_back({1'b1, f_go});
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    tv.push_back({1'b1, dec});
    for (int k = 0; k < 4; k++) tv.push_back({1'b1, E(6,0,0,0,0,0,0,0,0,0,0,0,0,1)});
`else
    tv.push_back({1'b1, E(1,0,0,0,0,1,0,0,0,0,0,0,0,0)});
    tv.push_back({1'b0, f_wait});
`endif
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL illegal cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_access();
    logic [19:0] tv[$];
    opcode = 7'b0110011;
    tv.push_back({1'b1, f_go});
    tv.push_back({1'b1, dec});
    tv.push_back({1'b1, E(2,0,0,0,0,0,0,2,0,0,0,0,0,0)});
    foreach (tv[k]) begin
      mem_ready = tv[k][19];
      @(negedge clk); checks++;
      if (obs !== tv[k][18:0]) begin failures++; $display("FAIL mid_reset cyc%0d got=%h exp=%h", k, obs, tv[k][18:0]); end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk); checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL mid_reset_wb_suppressed got=%h exp=%h", obs, 19'h0); end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk); checks++;
    if (obs !== f_wait) begin failures++; $display("FAIL mid_reset_refetch got=%h exp=%h", obs, f_wait); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; opcode = 7'h0;
    f_go   = E(0,1,0,0,1,0,0,0,0,0,0,0,0,0);
    f_wait = E(0,1,0,0,0,0,0,0,0,0,0,0,0,0);
    dec    = E(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    test_reset();
    test_r_type();
    test_i_type();
    test_load_wait();
    test_store();
    test_branch();
    test_jumps();
    test_fetch_timeout();
    test_limit_win();
    test_mem_timeout();
    test_halt();
    test_illegal();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
